branch_resolve_unit: RTL and testbench

Tracks each fetched instruction's branch prediction through a shadow pipeline alongside ID/EX to MEM. Compares the prediction with the real branch outcome at MEM. Drives the fetch-side redirect and the BTB update port of `branch_predictor` (`update_en`, `update_pc`, `update_target`). It sits between the fetch-stage predictor outputs and the MEM-stage branch resolution logic, closing the prediction loop.

---
 rtl/branch_pkg.sv | 14 +
 rtl/pred_shadow_pipe.sv | 29 ++
 rtl/branch_resolve_unit.sv | 115 +++++++++++
 tb/tb_branch_resolve_unit.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/branch_pkg.sv
// Shared types and constants for the branch resolve slice: shadow-pipe entry layout and PC step.
package branch_pkg;

  localparam int          PIPE_DEPTH_DEFAULT = 3;
  localparam logic [31:0] PC_STEP            = 32'd4;

  typedef struct packed {
    logic        valid;
    logic [31:0] pc;
    logic        pred_taken;
    logic [31:0] pred_target;
  } pred_entry_t;

endpackage

// File: rtl/pred_shadow_pipe.sv
// Delay line of fetch predictions, one entry per stage up to MEM; latency DEPTH unstalled edges.
// i_stall freezes every stage; i_clear or i_reset empties the whole line on the next edge.
module pred_shadow_pipe
  import branch_pkg::*;
#(
  parameter int DEPTH = PIPE_DEPTH_DEFAULT
) (
  input  logic        i_clk,
  input  logic        i_reset,
  input  logic        i_stall,
  input  logic        i_clear,
  input  pred_entry_t i_entry,
  output pred_entry_t o_mem_entry
);

  pred_entry_t r_stage [DEPTH];

  always_ff @(posedge i_clk) begin
    if (i_reset || i_clear) begin
      for (int i = 0; i < DEPTH; i++) r_stage[i] <= '0;
    end else if (!i_stall) begin
      r_stage[0] <= i_entry;
      for (int i = 1; i < DEPTH; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_mem_entry = r_stage[DEPTH-1];

endmodule

// File: rtl/branch_resolve_unit.sv
// Closes the prediction loop: shadows fetch predictions to MEM, compares with the resolved branch and
// drives a registered redirect / BTB update one edge later; stall freezes resolution. Counters: BRANCH_STATS_EN.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int PIPE_DEPTH = PIPE_DEPTH_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        f_valid,
  input  logic [31:0] f_pc,
  input  logic        f_pred_taken,
  input  logic [31:0] f_pred_target,
  input  logic        stall,
  input  logic        m_is_branch,
  input  logic        m_taken,
  input  logic [31:0] m_target,
  output logic        redirect,
  output logic [31:0] redirect_pc,
  output logic        update_en,
  output logic [31:0] update_pc,
  output logic [31:0] update_target,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispredicts
);

  pred_entry_t w_f_entry;
  pred_entry_t w_m;
  logic        w_resolve;
  logic        w_actual_taken;
  logic        w_mispredict;
  logic        w_update;
  logic        w_flush;
  logic [31:0] w_next_pc;

  logic        r_redirect;
  logic [31:0] r_redirect_pc;
  logic        r_update_en;
  logic [31:0] r_update_pc;
  logic [31:0] r_update_target;

  // The slot fetched while redirect is high is on the wrong path.
  assign w_f_entry = '{valid:       f_valid & ~r_redirect,
                       pc:          f_pc,
                       pred_taken:  f_pred_taken,
                       pred_target: f_pred_target};

  pred_shadow_pipe #(
    .DEPTH(PIPE_DEPTH)
  ) u_shadow (
    .i_clk      (clk),
    .i_reset    (reset),
    .i_stall    (stall),
    .i_clear    (w_flush),
    .i_entry    (w_f_entry),
    .o_mem_entry(w_m)
  );

  assign w_resolve      = w_m.valid & ~stall;
  assign w_actual_taken = m_is_branch & m_taken;
  assign w_next_pc      = m_taken ? m_target : w_m.pc + PC_STEP;
  assign w_mispredict   = (w_m.pred_taken != w_actual_taken)
                        | (w_m.pred_taken & w_actual_taken & (w_m.pred_target != m_target))
                        | (~m_is_branch & w_m.pred_taken);
  assign w_update       = (w_actual_taken & w_mispredict) | (w_m.pred_taken & ~w_actual_taken);
  assign w_flush        = w_resolve & w_mispredict;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_redirect      <= 1'b0;
      r_redirect_pc   <= '0;
      r_update_en     <= 1'b0;
      r_update_pc     <= '0;
      r_update_target <= '0;
    end else begin
      r_redirect  <= w_flush;
      r_update_en <= w_resolve & w_update;
      if (w_flush) r_redirect_pc <= w_next_pc;
      if (w_resolve && w_update) begin
        r_update_pc     <= w_m.pc;
        r_update_target <= w_next_pc;
      end
    end
  end

  assign redirect      = r_redirect;
  assign redirect_pc   = r_redirect_pc;
  assign update_en     = r_update_en;
  assign update_pc     = r_update_pc;
  assign update_target = r_update_target;

`ifdef BRANCH_STATS_EN
  logic [31:0] r_stat_branches;
  logic [31:0] r_stat_mispredicts;

  always_ff @(posedge clk) begin
    if (reset) begin
      r_stat_branches    <= '0;
      r_stat_mispredicts <= '0;
    end else begin
      if (w_resolve && m_is_branch && (r_stat_branches != '1))
        r_stat_branches <= r_stat_branches + 32'd1;
      if (w_flush && (r_stat_mispredicts != '1))
        r_stat_mispredicts <= r_stat_mispredicts + 32'd1;
    end
  end

  assign stat_branches    = r_stat_branches;
  assign stat_mispredicts = r_stat_mispredicts;
`else
  assign stat_branches    = '0;
  assign stat_mispredicts = '0;
`endif

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: expected strobes queued at stimulus, popped after each edge.
module tb_branch_resolve_unit;

  localparam int DEPTH = 3;
  localparam int B2B_N = 8;

`ifdef BRANCH_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        f_valid;
  logic [31:0] f_pc;
  logic        f_pred_taken;
  logic [31:0] f_pred_target;
  logic        stall;
  logic        m_is_branch;
  logic        m_taken;
  logic [31:0] m_target;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic        update_en;
  logic [31:0] update_pc;
  logic [31:0] update_target;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  branch_resolve_unit #(.PIPE_DEPTH(DEPTH)) dut (
    .clk             (clk),
    .reset           (reset),
    .f_valid         (f_valid),
    .f_pc            (f_pc),
    .f_pred_taken    (f_pred_taken),
    .f_pred_target   (f_pred_target),
    .stall           (stall),
    .m_is_branch     (m_is_branch),
    .m_taken         (m_taken),
    .m_target        (m_target),
    .redirect        (redirect),
    .redirect_pc     (redirect_pc),
    .update_en       (update_en),
    .update_pc       (update_pc),
    .update_target   (update_target),
    .stat_branches   (stat_branches),
    .stat_mispredicts(stat_mispredicts)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic        rd;
    logic [31:0] rpc;
    logic        up;
    logic [31:0] upc;
    logic [31:0] utgt;
  } exp_t;

  exp_t        sb[$];
  int          n_vec = 0;
  int          n_err = 0;
  int unsigned exp_br = 0;
  int unsigned exp_mp = 0;

  // Data fields only matter while their strobe is high.
  function automatic exp_t mk_exp(input logic rd, input logic [31:0] rpc, input logic up,
                                  input logic [31:0] upc, input logic [31:0] utgt);
    exp_t e;
    e.rd   = rd;
    e.rpc  = rd ? rpc : 32'd0;
    e.up   = up;
    e.upc  = up ? upc : 32'd0;
    e.utgt = up ? utgt : 32'd0;
    return e;
  endfunction

  function automatic exp_t observe();
    return mk_exp(redirect, redirect_pc, update_en, update_pc, update_target);
  endfunction

  function automatic exp_t model(input logic [31:0] pc, input logic pt, input logic [31:0] ptgt,
                                 input logic isb, input logic tk, input logic [31:0] tgt);
    logic        at;
    logic [31:0] npc;
    logic        mp;
    logic        up;
    at  = isb && tk;
    npc = tk ? tgt : pc + 32'd4;
    mp  = (pt != at) || (pt && at && (ptgt != tgt)) || (!isb && pt);
    up  = (at && mp) || (pt && !at);
    return mk_exp(mp, npc, up, pc, npc);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    f_valid = 0; f_pc = '0; f_pred_taken = 0; f_pred_target = '0;
    stall = 0; m_is_branch = 0; m_taken = 0; m_target = '0;
  endtask

  task automatic fetch_to_mem(input logic [31:0] pc, input logic pt, input logic [31:0] ptgt);
    f_valid = 1; f_pc = pc; f_pred_taken = pt; f_pred_target = ptgt;
    tick();
    f_valid = 0;
    repeat (DEPTH - 1) tick();
  endtask

  task automatic resolve(input logic isb, input logic tk, input logic [31:0] tgt, input exp_t e);
    m_is_branch = isb; m_taken = tk; m_target = tgt;
    sb.push_back(e);
    tick();
    m_is_branch = 0; m_taken = 0; m_target = '0;
  endtask

  task automatic test_reset();
    n_vec++;
    if ({redirect, redirect_pc, update_en, update_pc, update_target} !== 98'd0) begin
      n_err++;
      $display("FAIL reset_outputs: got rd=%0b rpc=%h up=%0b upc=%h utgt=%h, want all 0",
               redirect, redirect_pc, update_en, update_pc, update_target);
    end
    n_vec++;
    if ({stat_branches, stat_mispredicts} !== 64'd0) begin
      n_err++;
      $display("FAIL reset_stats: got br=%0d mp=%0d, want 0 0", stat_branches, stat_mispredicts);
    end
  endtask

  task automatic test_correct_taken();
    exp_t e, got;
    fetch_to_mem(32'h100, 1'b1, 32'h200);
    resolve(1'b1, 1'b1, 32'h200, mk_exp(0, 0, 0, 0, 0));
    exp_br++;
    got = observe(); e = sb.pop_front(); n_vec++;
    if (got !== e) begin
      n_err++; $display("FAIL correct_taken: got %h want %h", got, e);
    end
    n_vec++;
    if (stat_branches !== (STATS ? exp_br : 32'd0)) begin
      n_err++; $display("FAIL correct_taken_stat: got %0d want %0d", stat_branches, STATS ? exp_br : 0);
    end
  endtask

  task automatic test_cold_miss();
    exp_t e, got;
    f_valid = 1; f_pred_taken = 0; f_pred_target = '0;
    f_pc = 32'h40; tick();
    f_pc = 32'h44; tick();
    f_pc = 32'h48; tick();
    // Slot fetched in the resolving cycle must be dropped by the flush.
    f_pc = 32'h4C;
    resolve(1'b1, 1'b1, 32'h80, mk_exp(1, 32'h80, 1, 32'h40, 32'h80));
    exp_br++; exp_mp++;
    got = observe(); e = sb.pop_front(); n_vec++;
    if (got !== e) begin
      n_err++; $display("FAIL cold_miss: got %h want %h", got, e);
    end
    f_pc = 32'h50; m_is_branch = 1; m_taken = 1; m_target = 32'h900;
    tick();
    f_valid = 0;
    n_vec++;
    if (redirect !== 1'b0 || update_en !== 1'b0 || redirect_pc !== 32'h80 ||
        update_pc !== 32'h40 || update_target !== 32'h80) begin
      n_err++;
      $display("FAIL pulse_fall_hold: got rd=%0b up=%0b rpc=%h upc=%h utgt=%h want 0 0 80 40 80",
               redirect, update_en, redirect_pc, update_pc, update_target);
    end
    for (int i = 0; i < DEPTH + 1; i++) begin
      tick();
      n_vec++;
      if (redirect !== 1'b0) begin
        n_err++; $display("FAIL flush_pipe_empty[%0d]: redirect=%0b want 0", i, redirect);
      end
    end
    m_is_branch = 0; m_taken = 0; m_target = '0;
    n_vec++;
    if (stat_branches !== (STATS ? exp_br : 32'd0) || stat_mispredicts !== (STATS ? exp_mp : 32'd0)) begin
      n_err++; $display("FAIL cold_miss_stats: got %0d/%0d want %0d/%0d", stat_branches,
                        stat_mispredicts, STATS ? exp_br : 0, STATS ? exp_mp : 0);
    end
  endtask

  task automatic test_wrong_target();
    exp_t e, got;
    fetch_to_mem(32'h2F0, 1'b1, 32'h300);
    resolve(1'b1, 1'b1, 32'h340, mk_exp(1, 32'h340, 1, 32'h2F0, 32'h340));
    exp_br++; exp_mp++;
    got = observe(); e = sb.pop_front(); n_vec++;
    if (got !== e) begin
      n_err++; $display("FAIL wrong_target: got %h want %h", got, e);
    end
    tick();
  endtask

  task automatic test_pred_taken_not_taken();
    exp_t e, got;
    fetch_to_mem(32'h1C, 1'b1, 32'h80);
    resolve(1'b1, 1'b0, 32'h80, mk_exp(1, 32'h20, 1, 32'h1C, 32'h20));
    exp_br++; exp_mp++;
    got = observe(); e = sb.pop_front(); n_vec++;
    if (got !== e) begin
      n_err++; $display("FAIL pred_taken_not_taken: got %h want %h", got, e);
    end
    tick();
    // Stale alias: non-branch predicted taken.
    fetch_to_mem(32'h60, 1'b1, 32'h90);
    resolve(1'b0, 1'b0, 32'h0, mk_exp(1, 32'h64, 1, 32'h60, 32'h64));
    exp_mp++;
    got = observe(); e = sb.pop_front(); n_vec++;
    if (got !== e) begin
      n_err++; $display("FAIL alias_mispredict: got %h want %h", got, e);
    end
    tick();
    fetch_to_mem(32'h70, 1'b0, 32'h0);
    resolve(1'b1, 1'b0, 32'h123, mk_exp(0, 0, 0, 0, 0));
    exp_br++;
    got = observe(); e = sb.pop_front(); n_vec++;
    if (got !== e) begin
      n_err++; $display("FAIL correct_not_taken: got %h want %h", got, e);
    end
    n_vec++;
    if (stat_branches !== (STATS ? exp_br : 32'd0) || stat_mispredicts !== (STATS ? exp_mp : 32'd0)) begin
      n_err++; $display("FAIL not_taken_stats: got %0d/%0d want %0d/%0d", stat_branches,
                        stat_mispredicts, STATS ? exp_br : 0, STATS ? exp_mp : 0);
    end
  endtask

  task automatic test_stall_at_mem();
    exp_t e, got;
    fetch_to_mem(32'h500, 1'b0, 32'h0);
    m_is_branch = 1; m_taken = 1; m_target = 32'h600; stall = 1;
    for (int i = 0; i < 4; i++) begin
      sb.push_back(mk_exp(0, 0, 0, 0, 0));
      tick();
      got = observe(); e = sb.pop_front(); n_vec++;
      if (got !== e) begin
        n_err++; $display("FAIL stall_hold[%0d]: got %h want %h", i, got, e);
      end
    end
    stall = 0;
    resolve(1'b1, 1'b1, 32'h600, mk_exp(1, 32'h600, 1, 32'h500, 32'h600));
    exp_br++; exp_mp++;
    got = observe(); e = sb.pop_front(); n_vec++;
    if (got !== e) begin
      n_err++; $display("FAIL stall_release: got %h want %h", got, e);
    end
    // Pulse must fall even if the pipe is stalled.
    stall = 1;
    sb.push_back(mk_exp(0, 0, 0, 0, 0));
    tick();
    stall = 0;
    got = observe(); e = sb.pop_front(); n_vec++;
    if (got !== e) begin
      n_err++; $display("FAIL stall_single_pulse: got %h want %h", got, e);
    end
    n_vec++;
    if (stat_branches !== (STATS ? exp_br : 32'd0) || stat_mispredicts !== (STATS ? exp_mp : 32'd0)) begin
      n_err++; $display("FAIL stall_stats: got %0d/%0d want %0d/%0d", stat_branches,
                        stat_mispredicts, STATS ? exp_br : 0, STATS ? exp_mp : 0);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] pc_a   [B2B_N];
    logic        pt_a   [B2B_N];
    logic [31:0] ptgt_a [B2B_N];
    logic        isb_a  [B2B_N];
    logic        tk_a   [B2B_N];
    logic [31:0] tgt_a  [B2B_N];
    exp_t e, got;
    for (int k = 0; k < B2B_N; k++) begin
      pc_a[k]   = 32'h1000 + 32'(4 * k);
      pt_a[k]   = 1'($urandom_range(0, 1));
      ptgt_a[k] = 32'h4000 + 32'($urandom_range(0, 63)) * 32'd4;
      if (k == B2B_N - 1) begin
        isb_a[k] = 1; tk_a[k] = ~pt_a[k]; tgt_a[k] = 32'h2000;
      end else if (pt_a[k]) begin
        isb_a[k] = 1; tk_a[k] = 1; tgt_a[k] = ptgt_a[k];
      end else begin
        isb_a[k] = 1'($urandom_range(0, 1)); tk_a[k] = 0; tgt_a[k] = 32'($urandom);
      end
    end
    for (int c = 0; c < B2B_N + DEPTH; c++) begin
      f_valid = (c < B2B_N);
      if (c < B2B_N) begin
        f_pc = pc_a[c]; f_pred_taken = pt_a[c]; f_pred_target = ptgt_a[c];
      end
      if (c >= DEPTH) begin
        int k;
        k = c - DEPTH;
        m_is_branch = isb_a[k]; m_taken = tk_a[k]; m_target = tgt_a[k];
        e = model(pc_a[k], pt_a[k], ptgt_a[k], isb_a[k], tk_a[k], tgt_a[k]);
        if (isb_a[k]) exp_br++;
        if (e.rd) exp_mp++;
      end else begin
        m_is_branch = 0; m_taken = 0; m_target = '0;
        e = mk_exp(0, 0, 0, 0, 0);
      end
      sb.push_back(e);
      tick();
      got = observe(); e = sb.pop_front(); n_vec++;
      if (got !== e) begin
        n_err++; $display("FAIL back_to_back[%0d]: got %h want %h", c, got, e);
      end
    end
    idle_inputs();
    tick();
    n_vec++;
    if (stat_branches !== (STATS ? exp_br : 32'd0) || stat_mispredicts !== (STATS ? exp_mp : 32'd0)) begin
      n_err++; $display("FAIL back_to_back_stats: got %0d/%0d want %0d/%0d", stat_branches,
                        stat_mispredicts, STATS ? exp_br : 0, STATS ? exp_mp : 0);
    end
  endtask

  task automatic test_reset_midflight();
    fetch_to_mem(32'h700, 1'b0, 32'h0);
    m_is_branch = 1; m_taken = 1; m_target = 32'h780; reset = 1;
    tick();
    reset = 0;
    exp_br = 0; exp_mp = 0;
    n_vec++;
    if ({redirect, redirect_pc, update_en, update_pc, update_target, stat_branches, stat_mispredicts} !== 162'd0) begin
      n_err++;
      $display("FAIL reset_midflight: got rd=%0b rpc=%h up=%0b upc=%h utgt=%h br=%0d mp=%0d, want all 0",
               redirect, redirect_pc, update_en, update_pc, update_target, stat_branches, stat_mispredicts);
    end
    for (int i = 0; i < DEPTH + 1; i++) begin
      tick();
      n_vec++;
      if (redirect !== 1'b0) begin
        n_err++; $display("FAIL reset_pipe_empty[%0d]: redirect=%0b want 0", i, redirect);
      end
    end
    idle_inputs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1);
  end

  initial begin
    idle_inputs();
    reset = 1;
    repeat (2) tick();
    test_reset();
    reset = 0;
    tick();
    test_correct_taken();
    test_cold_miss();
    test_wrong_target();
    test_pred_taken_not_taken();
    test_stall_at_mem();
    test_back_to_back();
    test_reset_midflight();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
